// File: rtl/mcycle_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_unit_if
//  Description : Start/Busy/Done handshake and operand/result bus of the
//                iterative multiply/divide unit.
//                master : requester (drives Start, MCycleOp, Operand1/2)
//                slave  : mcycle_unit (drives Result1/2, Busy, Done)
//                Start     - request, sampled only while the unit is idle
//                MCycleOp  - bit1: 0 mul / 1 div, bit0: 0 signed / 1 unsigned
//                Operand1  - multiplicand or dividend
//                Operand2  - multiplier or divisor
//                Result1   - product low half, or quotient
//                Result2   - product high half, or remainder
//                Busy      - operation in progress
//                Done      - one-cycle completion pulse
//                DivByZero - only with MCYCLE_DIV0_EN defined; pulses with
//                            Done for a divide by zero
//  Revision    : 1.0 - initial release
// ============================================================================
interface mcycle_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;
`ifdef MCYCLE_DIV0_EN
    logic             DivByZero;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done, DivByZero
    );
    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done, DivByZero
    );
`else
    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );
    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );
`endif
endinterface : mcycle_unit_if
`default_nettype wire

// File: rtl/mcycle_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_unit
//  Description : Parametrised iterative multiply/divide unit. Signed and
//                unsigned MUL (full 2*WIDTH product, radix-2 shift-add) and
//                DIV (restoring, one quotient bit per cycle, MSB first).
//                Start edge to Done edge is WIDTH+1 clocks.
//  Ports       : CLK    - rising-edge clock
//                RESETn - asynchronous active-low reset
//                bus    - mcycle_unit_if.slave (Start/MCycleOp/Operand1/2 in,
//                         Result1/2, Busy, Done [, DivByZero] out)
//  Options     : MCYCLE_DIV0_EN - adds DivByZero output; a divide by zero
//                skips the iteration phase and completes one edge after Start.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic          CLK,
    input  logic          RESETn,
    mcycle_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_FINISH  = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide  : {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    // Multiplicand magnitude (mul) or divisor magnitude (div).
    logic [WIDTH-1:0]     opb_q,    opb_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q,    neg_d;     // product / quotient negative
    logic                 neg_r_q,  neg_r_d;   // remainder negative (dividend sign)
    logic                 div0_q,   div0_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;
    logic [WIDTH-1:0]     res1_q,   res1_d;
    logic [WIDTH-1:0]     res2_q,   res2_d;
`ifdef MCYCLE_DIV0_EN
    logic                 dz_q,     dz_d;
`endif

    // ------------------------------------------------------------------
    // Operand conditioning at the Start edge
    // ------------------------------------------------------------------
    logic                 w_signed;
    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic                 w_div0_in;

    assign w_signed  = ~bus.MCycleOp[0];
    assign w_mag1    = (w_signed && bus.Operand1[WIDTH-1]) ? -bus.Operand1 : bus.Operand1;
    assign w_mag2    = (w_signed && bus.Operand2[WIDTH-1]) ? -bus.Operand2 : bus.Operand2;
    assign w_div0_in = bus.MCycleOp[1] && (bus.Operand2 == {WIDTH{1'b0}});

    // ------------------------------------------------------------------
    // One iteration of each datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_add;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_div_next;

    // Shift-add: conditionally add the multiplicand into the high half, then
    // shift the whole accumulator (including the carry) right by one.
    assign w_add      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                      + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    assign w_mul_next = {w_add, acc_q[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. The remainder before the shift is
    // always below the divisor, so the difference fits in WIDTH bits.
    assign w_rem      = acc_q[2*WIDTH-1:WIDTH-1];
    assign w_ge       = (w_rem >= {1'b0, opb_q});
    assign w_diff     = w_rem[WIDTH-1:0] - opb_q;
    assign w_div_next = {(w_ge ? w_diff : w_rem[WIDTH-1:0]), acc_q[WIDTH-2:0], w_ge};

    // ------------------------------------------------------------------
    // Sign correction at FINISH
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_remf;

    assign w_prod = neg_q ? -acc_q : acc_q;
    // With a zero divisor every trial subtraction succeeds, so the remainder
    // register ends up holding the dividend magnitude; re-applying the
    // dividend sign restores the original Operand1.
    assign w_quo  = div0_q  ? {WIDTH{1'b1}}
                  : (neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign w_remf = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        neg_r_d  = neg_r_q;
        div0_d   = div0_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        res1_d   = res1_q;
        res2_d   = res2_q;
`ifdef MCYCLE_DIV0_EN
        dz_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    is_div_d = bus.MCycleOp[1];
                    neg_d    = w_signed && (bus.Operand1[WIDTH-1] ^ bus.Operand2[WIDTH-1]);
                    neg_r_d  = w_signed && bus.Operand1[WIDTH-1];
                    div0_d   = w_div0_in;
                    cnt_d    = {CNT_W{1'b0}};
                    busy_d   = 1'b1;
                    state_d  = S_COMPUTE;
                    if (bus.MCycleOp[1]) begin
                        acc_d = {{WIDTH{1'b0}}, w_mag1};
                        opb_d = w_mag2;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, w_mag2};
                        opb_d = w_mag1;
                    end
`ifdef MCYCLE_DIV0_EN
                    // Preload what the iterations would have produced and
                    // go straight to sign correction.
                    if (w_div0_in) begin
                        acc_d   = {w_mag1, {WIDTH{1'b1}}};
                        state_d = S_FINISH;
                    end
`endif
                end
            end
            S_COMPUTE: begin
                acc_d = is_div_q ? w_div_next : w_mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                if (is_div_q) begin
                    res1_d = w_quo;
                    res2_d = w_remf;
                end else begin
                    res1_d = w_prod[WIDTH-1:0];
                    res2_d = w_prod[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
`ifdef MCYCLE_DIV0_EN
                dz_d    = is_div_q && div0_q;
`endif
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            opb_q    <= {WIDTH{1'b0}};
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res1_q   <= {WIDTH{1'b0}};
            res2_q   <= {WIDTH{1'b0}};
`ifdef MCYCLE_DIV0_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            neg_r_q  <= neg_r_d;
            div0_q   <= div0_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res1_q   <= res1_d;
            res2_q   <= res2_d;
`ifdef MCYCLE_DIV0_EN
            dz_q     <= dz_d;
`endif
        end
    end

    assign bus.Result1   = res1_q;
    assign bus.Result2   = res2_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
`ifdef MCYCLE_DIV0_EN
    assign bus.DivByZero = dz_q;
`endif

endmodule : mcycle_unit
`default_nettype wire

// File: tb/tb_mcycle_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcycle_unit
//  Description : Scoreboard bench for mcycle_unit (WIDTH=8). The driver
//                pushes reference results computed with plain integer
//                arithmetic; a negedge monitor pops and compares on Done and
//                checks latency, Busy duration, Done pulse width and result
//                hold. Honours MCYCLE_DIV0_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcycle_unit;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        int           start;
        int           lat;
        bit           dz;
    } exp_t;

    logic CLK;
    logic RESETn;
    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    mcycle_unit_if #(.WIDTH(W)) bus ();

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: results straight from integer arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int start);
        exp_t        e;
        longint      x, y, p;
        logic [63:0] v;
        e.start = start;
        e.dz    = op[1] && (b == '0);
        if (op[0]) begin
            x = longint'(a);
            y = longint'(b);
        end else begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end
        if (!op[1]) begin
            p = x * y;
            v = p;
            e.r1 = v[W-1:0];
            e.r2 = v[2*W-1:W];
        end else if (b == '0) begin
            e.r1 = '1;
            e.r2 = a;
        end else begin
            p = x / y;
            v = p;
            e.r1 = v[W-1:0];
            p = x % y;
            v = p;
            e.r2 = v[W-1:0];
        end
`ifdef MCYCLE_DIV0_EN
        e.lat = e.dz ? 1 : W + 1;
`else
        e.lat = W + 1;
`endif
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = 1;
            2:       v = '1;
            3:       v = {1'b1, {(W-1){1'b0}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Called at a negedge. Waits for the unit to be idle (optionally holding
    // Start with junk operands meanwhile), then issues one operation.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit hold);
        int guard = 0;
        while (bus.Busy !== 1'b0 && guard < 4 * W) begin
            bus.Start    = hold ? 1'b1 : 1'($urandom_range(0, 1));
            bus.MCycleOp = 2'($urandom);
            bus.Operand1 = W'($urandom);
            bus.Operand2 = W'($urandom);
            @(negedge CLK);
            guard++;
        end
        if (guard >= 4 * W) chk("busy_timeout", bus.Busy, 1'b0);
        if (!hold && $urandom_range(0, 3) == 0) begin
            bus.Start = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge CLK);
        end
        bus.Start    = 1'b1;
        bus.MCycleOp = op;
        bus.Operand1 = a;
        bus.Operand2 = b;
        exp_q.push_back(model(op, a, b, cyc + 1));
        @(negedge CLK);
    endtask

    task automatic drain();
        int g = 0;
        bus.Start = 1'b0;
        while (exp_q.size() > 0 && g < 4 * W + 8) begin
            @(negedge CLK);
            g++;
        end
        chk("drain_pending", 32'(exp_q.size()), 0);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin : monitor
        int           busy_cnt;
        bit           done_prev;
        logic [W-1:0] last_r1;
        logic [W-1:0] last_r2;
        exp_t         e;
        busy_cnt  = 0;
        done_prev = 1'b0;
        last_r1   = '0;
        last_r2   = '0;
        forever begin
            @(negedge CLK);
            if (RESETn !== 1'b1) begin
                exp_q.delete();
                busy_cnt  = 0;
                done_prev = 1'b0;
                last_r1   = '0;
                last_r2   = '0;
            end else begin
                if (bus.Busy === 1'b1) busy_cnt++;
                if (bus.Done === 1'b1) begin
                    chk("done_single_cycle", done_prev, 1'b0);
                    chk("busy_low_at_done", bus.Busy, 1'b0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done actual=Done required=no_pending_op (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result1", bus.Result1, e.r1);
                        chk("result2", bus.Result2, e.r2);
                        chk("latency", 32'(cyc - e.start), 32'(e.lat));
                        chk("busy_cycles", 32'(busy_cnt), 32'(e.lat));
`ifdef MCYCLE_DIV0_EN
                        chk("divbyzero", bus.DivByZero, e.dz);
`endif
                        last_r1 = e.r1;
                        last_r2 = e.r2;
                    end
                    busy_cnt  = 0;
                    done_prev = 1'b1;
                end else begin
                    chk("result1_hold", bus.Result1, last_r1);
                    chk("result2_hold", bus.Result2, last_r2);
`ifdef MCYCLE_DIV0_EN
                    chk("divbyzero_low", bus.DivByZero, 1'b0);
`endif
                    done_prev = 1'b0;
                    if (exp_q.size() > 0 && (cyc - exp_q[0].start) > exp_q[0].lat + 3) begin
                        chk("done_timeout", bus.Done, 1'b1);
                        void'(exp_q.pop_front());
                        busy_cnt = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    initial begin : driver
        logic [1:0] op;
        RESETn       = 1'b0;
        bus.Start    = 1'b0;
        bus.MCycleOp = 2'b00;
        bus.Operand1 = '0;
        bus.Operand2 = '0;
        checks       = 0;
        errors       = 0;
        repeat (3) @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
        chk("reset_busy",    bus.Busy,    1'b0);
        chk("reset_done",    bus.Done,    1'b0);
        chk("reset_result1", bus.Result1, '0);
        chk("reset_result2", bus.Result2, '0);

        // Directed cases, Start held high throughout (back-to-back issue).
        run_op(2'b00, 8'hFD, 8'h07, 1'b1);  // -3 * 7
        run_op(2'b01, 8'hFF, 8'hFF, 1'b1);  // unsigned max * max
        run_op(2'b10, 8'hF9, 8'h02, 1'b1);  // -7 / 2
        run_op(2'b10, 8'h80, 8'hFF, 1'b1);  // MIN / -1
        run_op(2'b11, 8'd200, 8'd7, 1'b1);  // 200 / 7
        run_op(2'b11, 8'h35, 8'h00, 1'b1);  // unsigned divide by zero
        run_op(2'b10, 8'hB5, 8'h00, 1'b1);  // signed divide by zero
        run_op(2'b10, 8'h07, 8'hFE, 1'b1);  // 7 / -2
        run_op(2'b10, 8'hF9, 8'hFE, 1'b1);  // -7 / -2
        run_op(2'b00, 8'h80, 8'h80, 1'b1);  // MIN * MIN
        run_op(2'b01, 8'h00, 8'hC3, 1'b1);  // multiply by zero
        drain();

        // Asynchronous reset in the middle of a multiply.
        run_op(2'b01, 8'hE7, 8'h9B, 1'b0);
        bus.Start = 1'b0;
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #2 RESETn = 1'b0;
        #1;
        chk("midreset_busy",    bus.Busy,    1'b0);
        chk("midreset_done",    bus.Done,    1'b0);
        chk("midreset_result1", bus.Result1, '0);
        chk("midreset_result2", bus.Result2, '0);
        @(negedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
        run_op(2'b00, 8'h9C, 8'h3B, 1'b0);
        drain();

        // Randomised traffic with boundary-biased operands.
        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom);
            run_op(op, pick(), pick(), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mcycle_unit
`default_nettype wire
